mem_latency_responder: RTL and testbench
========================================

# mem_latency_responder

Synthesizable memory-side responder for the NPU request/response memory interface. It accepts read requests on a valid/ready handshake, holds up to `QUEUE_DEPTH` outstanding requests, and returns one response per request in issue order. Each response follows a per-request latency: a base SRAM or DRAM latency plus optional pseudo-random jitter. Unlike the single-outstanding latency injector, it supports multiple outstanding requests and honours response back-pressure (`resp_ready`). It sits behind DMA/compute-side initiators in system sims and CI latency-profiling benches.

## Interface
- `SIZE_WIDTH`, 16: width of request/response size field (bytes).
- `QUEUE_DEPTH`, 4: max outstanding requests; power of 2, 2..16.
- `LAT_SRAM`, 5: base SRAM latency, cycles; 1..255.
- `LAT_DRAM`, 12: base DRAM latency, cycles; 1..255.
- `EXTRA_LATENCY_MAX`, 8: jitter range 0..EXTRA_LATENCY_MAX; 0..255.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `req_valid`  in  1  request offered.
- `req_ready`  out  1  responder can accept.
- `req_is_dram`  in  1  1 = DRAM base latency, 0 = SRAM base latency.
- `req_size_bytes`  in  SIZE_WIDTH  request size.
- `resp_valid`  out  1  head response available.
- `resp_ready`  in  1  initiator accepts response.
- `resp_size_bytes`  out  SIZE_WIDTH  size of the returned request.
- `total_reqs`  out  32  accepted requests.
- `total_resp`  out  32  completed responses.
- `stall_cycles`  out  32  cycles with `resp_valid && !resp_ready`.
- `busy`  out  1  at least one request outstanding.

## Operation
- Circular FIFO with `QUEUE_DEPTH` entries. Each entry holds `size` and `remaining` (9 bits).
- Write and read pointers are log2(QUEUE_DEPTH)+1 bits, so full and empty are distinguishable.
- Accept: `req_valid && req_ready` at edge E0.
  - The tail entry is written with `remaining = base + extra`.
  - `base` is `LAT_DRAM` when `req_is_dram` is 1, otherwise `LAT_SRAM`.
  - `extra` is 0 when jitter is compiled out (see Configuration).
- Countdown: every entry with `remaining > 0` that is not being written decrements by 1 each edge. Non-head entries also count down, so latencies overlap. A value of 0 saturates.
- `resp_valid` is high when the head entry is valid and its `remaining == 0`. It is decoded from registers, with no combinational path from any input.
- `resp_size_bytes` shows the head entry's size whenever `resp_valid` is high, and 0 otherwise.
- Pop: `resp_valid && resp_ready` at an edge advances the read pointer.
- Ordering is strictly in issue order. A ready younger entry waits behind the head.
- `req_ready` is `occupancy < QUEUE_DEPTH`, decoded from registers only. There is no same-cycle pop bypass.
- Push and pop in the same cycle: both take effect, and occupancy is unchanged.
- Counters wrap modulo 2^32.
  - `total_reqs` increments on accept.
  - `total_resp` increments on pop.
  - `stall_cycles` increments on every edge where `resp_valid && !resp_ready`.
- `busy` is `occupancy != 0`.
- Reset, including mid-operation, discards all outstanding entries, with no response for them. After reset:
  - pointers, counters, `resp_valid`, `busy` and `resp_size_bytes` are 0;
  - `req_ready` is 1;
  - the LFSR returns to `LFSR_SEED`.

## Timing
- A request accepted at edge E0 with latency L shows `resp_valid` high in the cycle after edge E0+L, provided it is at the head and no back-pressure is applied.
- The minimum latency is therefore 1 cycle.
- Once asserted, `resp_valid` and `resp_size_bytes` stay stable until the pop edge.
- Throughput is at most one accept and one response per cycle.
- An entry behind a stalled head may reach `remaining == 0`. It then responds in the cycle after the head's pop edge.
- Reset asserted on edge R: all outputs hold their reset values from the cycle after R.

## Configuration
- Macro: `MEM_RESP_LFSR_JITTER_EN`.
- Defined:
  - 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1.
  - The LFSR advances one step on each accept.
  - `extra = lfsr[15:0] % (EXTRA_LATENCY_MAX+1)`, using the pre-advance value.
  - Latency for a given request is therefore uniform-ish over base..base+EXTRA_LATENCY_MAX and deterministic for a given seed.
- Undefined: no LFSR logic, `extra = 0`, latency exactly `LAT_SRAM` or `LAT_DRAM`. `EXTRA_LATENCY_MAX` and `LFSR_SEED` are ignored.

## Test plan
- Jitter off, `LAT_SRAM`=5: one SRAM request accepted at edge 10 with `resp_ready`=1 -> `resp_valid` high only in the cycle after edge 15, `total_resp`=1, `busy` back to 0.
- Jitter off: 4 back-to-back DRAM requests, `LAT_DRAM`=12 -> `req_ready` low after the 4th accept, responses on 4 consecutive cycles starting 12 edges after the first accept, sizes in issue order.
- Mixed ordering: DRAM (12) then SRAM (5) issued on consecutive edges -> the SRAM response is returned only after the DRAM pop, on the next cycle.
- Back-pressure: hold `resp_ready`=0 for 7 cycles while the head is ready -> `stall_cycles`=7, `resp_size_bytes` stable, no pop, no lost entries.
- Jitter on, `EXTRA_LATENCY_MAX`=8, 120 serial SRAM requests -> every latency in 5..13, at least 5 distinct values, identical sequence on rerun with the same seed.
- Reset asserted with 3 entries outstanding -> the next cycle shows `busy`=0, `resp_valid`=0, `req_ready`=1, counters 0, and no stale response ever appears.

Source files
------------

// File: rtl/mem_latency_responder.sv
// In-order memory responder: up to QUEUE_DEPTH outstanding reads, each returned after SRAM/DRAM base latency.
// Optional LFSR latency jitter is compiled in with `define MEM_RESP_LFSR_JITTER_EN.
module mem_latency_responder #(
    parameter int          SIZE_WIDTH        = 16,
    parameter int          QUEUE_DEPTH       = 4,
    parameter int          LAT_SRAM          = 5,
    parameter int          LAT_DRAM          = 12,
    parameter int          EXTRA_LATENCY_MAX = 8,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_is_dram_i,
    input  logic [SIZE_WIDTH-1:0] req_size_bytes_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [SIZE_WIDTH-1:0] resp_size_bytes_o,
    output logic [31:0]           total_reqs_o,
    output logic [31:0]           total_resp_o,
    output logic [31:0]           stall_cycles_o,
    output logic                  busy_o
);
    localparam int AW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_L = QUEUE_DEPTH[AW:0];

    // Extra pointer bit distinguishes full from empty.
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
    logic [SIZE_WIDTH-1:0] size_q [QUEUE_DEPTH];
    logic [8:0]            rem_q  [QUEUE_DEPTH];
    logic [31:0]           total_reqs_q, total_reqs_d, total_resp_q, total_resp_d;
    logic [31:0]           stall_q, stall_d;
    logic [AW-1:0]         wr_idx, rd_idx;
    logic                  push, pop;
    logic [8:0]            base, extra, lat;

    assign occ    = wr_ptr_q - rd_ptr_q;
    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    assign req_ready_o       = (occ != DEPTH_L);
    assign busy_o            = (occ != '0);
    assign resp_valid_o      = busy_o && (rem_q[rd_idx] == '0);
    assign resp_size_bytes_o = resp_valid_o ? size_q[rd_idx] : '0;
    assign total_reqs_o      = total_reqs_q;
    assign total_resp_o      = total_resp_q;
    assign stall_cycles_o    = stall_q;

    assign push = req_valid_i && req_ready_o;
    assign pop  = resp_valid_o && resp_ready_i;
    assign base = req_is_dram_i ? 9'(LAT_DRAM) : 9'(LAT_SRAM);
    assign lat  = base + extra;

`ifdef MEM_RESP_LFSR_JITTER_EN
    // Galois LFSR, x^16+x^14+x^13+x^11+1; jitter uses the value before this accept's step.
    logic [15:0] lfsr_q, lfsr_d;
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    assign extra  = 9'(lfsr_q % 16'(EXTRA_LATENCY_MAX + 1));

    always_ff @(posedge clk_i) begin
        if (reset_i)   lfsr_q <= LFSR_SEED;
        else if (push) lfsr_q <= lfsr_d;
    end
`else
    logic unused_jitter_cfg;
    assign unused_jitter_cfg = ^{16'(EXTRA_LATENCY_MAX), LFSR_SEED};
    assign extra = '0;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        total_reqs_d = total_reqs_q;
        total_resp_d = total_resp_q;
        stall_d      = stall_q;
        if (push) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            total_reqs_d = total_reqs_q + 32'd1;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + 1'b1;
            total_resp_d = total_resp_q + 32'd1;
        end
        if (resp_valid_o && !resp_ready_i) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            total_reqs_q <= '0;
            total_resp_q <= '0;
            stall_q      <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            total_reqs_q <= total_reqs_d;
            total_resp_q <= total_resp_d;
            stall_q      <= stall_d;
        end
    end

    // All entries count down in parallel so queued latencies overlap; 0 saturates.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (reset_i) begin
                rem_q[i]  <= '0;
                size_q[i] <= '0;
            end else if (push && (wr_idx == AW'(i))) begin
                rem_q[i]  <= lat;
                size_q[i] <= req_size_bytes_i;
            end else if (rem_q[i] != '0) begin
                rem_q[i]  <= rem_q[i] - 9'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_latency_responder.sv
// Directed bench for mem_latency_responder: vector table plus hand-written multi-cycle sequences.
module tb_mem_latency_responder;
    logic        clk = 1'b0;
    logic        reset, req_valid, req_is_dram, resp_ready;
    logic [15:0] req_size;
    logic        req_ready, resp_valid, busy;
    logic [15:0] resp_size;
    logic [31:0] total_reqs, total_resp, stall_cycles;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mem_latency_responder dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_is_dram_i     (req_is_dram),
        .req_size_bytes_i  (req_size),
        .resp_valid_o      (resp_valid),
        .resp_ready_i      (resp_ready),
        .resp_size_bytes_o (resp_size),
        .total_reqs_o      (total_reqs),
        .total_resp_o      (total_resp),
        .stall_cycles_o    (stall_cycles),
        .busy_o            (busy)
    );

    typedef struct {
        logic        rst, vld, dram, rdy;
        logic [15:0] size;
        logic        e_rr, e_rv, e_busy;
        logic [15:0] e_sz;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic rst, vld, dram, input logic [15:0] size, input logic rdy,
                       input logic e_rr, e_rv, input logic [15:0] e_sz, input logic e_busy);
        vec_t v;
        v.rst = rst; v.vld = vld; v.dram = dram; v.size = size; v.rdy = rdy;
        v.e_rr = e_rr; v.e_rv = e_rv; v.e_sz = e_sz; v.e_busy = e_busy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample on the following falling edge.
    task automatic cyc(input logic rst, vld, dram, input logic [15:0] size, input logic rdy);
        reset = rst; req_valid = vld; req_is_dram = dram; req_size = size; resp_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(input string tag, input logic e_rr, e_rv, input logic [15:0] e_sz,
                             input logic e_busy);
        chk({tag, ".req_ready"},  32'(req_ready),  32'(e_rr));
        chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(e_rv));
        chk({tag, ".resp_size"},  32'(resp_size),  32'(e_sz));
        chk({tag, ".busy"},       32'(busy),       32'(e_busy));
    endtask

    task automatic chk_cnt(input string tag, input int r, input int p, input int s);
        chk({tag, ".total_reqs"},   total_reqs,   32'(r));
        chk({tag, ".total_resp"},   total_resp,   32'(p));
        chk({tag, ".stall_cycles"}, stall_cycles, 32'(s));
    endtask

`ifdef MEM_RESP_LFSR_JITTER_EN
    int lat_run[2][120];

    task automatic jitter_run(input int r);
        int n;
        cyc(1, 0, 0, 0, 1);
        for (int k = 0; k < 120; k++) begin
            cyc(0, 1, 0, 16'(k), 0);
            n = 0;
            while (!resp_valid && n < 300) begin
                cyc(0, 0, 0, 0, 0);
                n++;
            end
            lat_run[r][k] = n;
            cyc(0, 0, 0, 0, 1);
        end
    endtask
`endif

    initial begin
        logic saw_stale;
        logic [15:0] dsz [4];
        reset = 1'b1; req_valid = 1'b0; req_is_dram = 1'b0; req_size = '0; resp_ready = 1'b1;
        @(negedge clk);

        // Single SRAM request (latency 5), then DRAM(12) followed by SRAM(5).
        add(1, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
        add(0, 1, 0, 16'h0040, 1,  1, 0, 16'h0000, 1);
        repeat (4) add(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 16'h0040, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);
        add(0, 1, 1, 16'h00D1, 1,  1, 0, 16'h0000, 1);
        add(0, 1, 0, 16'h0051, 1,  1, 0, 16'h0000, 1);
        repeat (10) add(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 16'h00D1, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 1, 16'h0051, 1);
        add(0, 0, 0, 16'h0000, 1,  1, 0, 16'h0000, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].vld, tbl[i].dram, tbl[i].size, tbl[i].rdy);
            chk_state($sformatf("vec%0d", i), tbl[i].e_rr, tbl[i].e_rv, tbl[i].e_sz, tbl[i].e_busy);
            if (i == 0) chk_cnt("vec0", 0, 0, 0);
        end
        chk_cnt("table_end", 3, 3, 0);

        // Four back-to-back DRAM requests fill the queue; a fifth offer must be refused.
        cyc(1, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) dsz[k] = 16'h0A00 + 16'(k);
        for (int n = 0; n <= 20; n++) begin
            if (n < 4)       cyc(0, 1, 1, dsz[n], 1);
            else if (n == 4) cyc(0, 1, 1, 16'hBEEF, 1);
            else             cyc(0, 0, 0, 0, 1);
            chk_state($sformatf("b2b_e%0d", n), !(n >= 3 && n <= 12), (n >= 12 && n <= 15),
                      (n >= 12 && n <= 15) ? dsz[(n >= 12 && n <= 15) ? n - 12 : 0] : 16'h0,
                      (n <= 15));
        end
        chk_cnt("b2b_end", 4, 4, 0);

        // Back-pressure: head ready but resp_ready held low for 7 edges.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 16'h0077, 0);
        cyc(0, 1, 0, 16'h0088, 0);
        for (int n = 2; n <= 5; n++) cyc(0, 0, 0, 0, 0);
        chk_state("bp_ready", 1, 1, 16'h0077, 1);
        for (int n = 0; n < 7; n++) begin
            cyc(0, 0, 0, 0, 0);
            chk_state($sformatf("bp_hold%0d", n), 1, 1, 16'h0077, 1);
        end
        chk_cnt("bp_hold", 2, 0, 7);
        cyc(0, 0, 0, 0, 1);
        chk_state("bp_pop1", 1, 1, 16'h0088, 1);
        cyc(0, 0, 0, 0, 1);
        chk_state("bp_pop2", 1, 0, 16'h0000, 0);
        chk_cnt("bp_end", 2, 2, 7);

        // Reset with three entries outstanding: nothing may come back afterwards.
        cyc(0, 1, 0, 16'h0011, 1);
        cyc(0, 1, 1, 16'h0022, 1);
        cyc(0, 1, 0, 16'h0033, 1);
        cyc(1, 0, 0, 0, 1);
        chk_state("rst_mid", 1, 0, 16'h0000, 0);
        chk_cnt("rst_mid", 0, 0, 0);
        saw_stale = 1'b0;
        for (int n = 0; n < 20; n++) begin
            cyc(0, 0, 0, 0, 1);
            if (resp_valid || busy) saw_stale = 1'b1;
        end
        chk("rst_no_stale", 32'(saw_stale), 32'd0);
        chk_cnt("rst_after", 0, 0, 0);

`ifdef MEM_RESP_LFSR_JITTER_EN
        begin
            logic [31:0] seen;
            int bad, distinct, diff;
            jitter_run(0);
            jitter_run(1);
            seen = '0; bad = 0; diff = 0;
            for (int k = 0; k < 120; k++) begin
                if (lat_run[0][k] < 5 || lat_run[0][k] > 13) bad++;
                else seen[lat_run[0][k]] = 1'b1;
                if (lat_run[0][k] != lat_run[1][k]) diff++;
            end
            distinct = $countones(seen);
            chk("jit_range", 32'(bad), 32'd0);
            chk("jit_distinct_ge5", 32'(distinct >= 5), 32'd1);
            chk("jit_repeat", 32'(diff), 32'd0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
